message_reg: RTL and testbench

//   Single-byte message holding register between the guess-entry logic and the UART

---
 rtl/message_reg.sv | 88 ++++++++
 tb/tb_message_reg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/message_reg.sv
// Single-byte message holding register between guess entry and the UART transmitter.
// Captures a byte on a rising ready, shows it pending on blue, hands it off with a one-cycle tx_ctrl.
module message_reg (
  input  logic       clk,
  input  logic       nRst,
  input  logic       ready,
  input  logic       transmit_ready,
  input  logic [7:0] data,
  output logic       blue,
  output logic       tx_ctrl,
  output logic [7:0] tx_byte
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] msg_q, msg_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       ready_q;
  logic       blue_q, blue_d;
  logic       tx_ctrl_q, tx_ctrl_d;
  logic       cap;

  // ready_q resets low, so a ready already high at reset release captures on the first edge.
  assign cap = ready & ~ready_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    msg_d     = msg_q;
    tx_byte_d = tx_byte_q;

    unique case (state_q)
      IDLE: begin
        if (cap) begin
          msg_d   = data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cap) begin
          msg_d = data;
        end else if (transmit_ready) begin
          tx_byte_d = msg_q;
          state_d   = SEND;
        end
      end
      SEND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    blue_d    = (state_d == HOLD);
    tx_ctrl_d = (state_d == SEND);
  end

  always_ff @(posedge clk or negedge nRst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!nRst) begin
      state_q   <= IDLE;
      msg_q     <= 8'h00;
      tx_byte_q <= 8'h00;
      ready_q   <= 1'b0;
      blue_q    <= 1'b0;
      tx_ctrl_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      tx_byte_q <= tx_byte_d;
      ready_q   <= ready;
      blue_q    <= blue_d;
      tx_ctrl_q <= tx_ctrl_d;
    end
  end

  assign blue    = blue_q;
  assign tx_ctrl = tx_ctrl_q;
  assign tx_byte = tx_byte_q;

endmodule

// File: tb/tb_message_reg.sv
// Directed self-checking bench for message_reg: capture, send, priority and async reset cases.
module tb_message_reg;

  logic       clk;
  logic       nRst;
  logic       ready;
  logic       transmit_ready;
  logic [7:0] data;
  logic       blue;
  logic       tx_ctrl;
  logic [7:0] tx_byte;

  int checks = 0;
  int errors = 0;

  message_reg dut (
    .clk           (clk),
    .nRst          (nRst),
    .ready         (ready),
    .transmit_ready(transmit_ready),
    .data          (data),
    .blue          (blue),
    .tx_ctrl       (tx_ctrl),
    .tx_byte       (tx_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic b, input logic t, input logic [7:0] byte_exp);
    check({tag, "_blue"}, {7'd0, blue}, {7'd0, b});
    check({tag, "_txctrl"}, {7'd0, tx_ctrl}, {7'd0, t});
    check({tag, "_txbyte"}, tx_byte, byte_exp);
  endtask

  initial begin
    // 1. Reset held for two cycles with data=5
    nRst = 1'b0; ready = 1'b0; transmit_ready = 1'b0; data = 8'h05;
    tick(); tick();
    check_out("reset", 1'b0, 1'b0, 8'h00);
    nRst = 1'b1;
    tick();
    check_out("idle_after_reset", 1'b0, 1'b0, 8'h00);

    // 2. Capture then send one cycle later
    ready = 1'b1; data = 8'h05;
    tick();
    check_out("cap_hold", 1'b1, 1'b0, 8'h00);
    transmit_ready = 1'b1;
    tick();
    check_out("cap_send", 1'b0, 1'b1, 8'h05);
    tick();
    check_out("cap_after", 1'b0, 1'b0, 8'h05);
    ready = 1'b0; transmit_ready = 1'b0;

    // 3. No input for three cycles: tx_byte holds
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("quiet", 1'b0, 1'b0, 8'h05);
    end

    // 4. Hold without send, data changes without re-capture
    ready = 1'b1; data = 8'h05;
    tick();
    check_out("hold1", 1'b1, 1'b0, 8'h05);
    data = 8'h77;
    tick();
    check_out("hold2", 1'b1, 1'b0, 8'h05);
    transmit_ready = 1'b1;
    tick();
    check_out("hold_send", 1'b0, 1'b1, 8'h05);

    // 5. ready held through and after the send: single pulse, no re-capture
    tick();
    check_out("held_ready1", 1'b0, 1'b0, 8'h05);
    tick();
    check_out("held_ready2", 1'b0, 1'b0, 8'h05);
    ready = 1'b0; transmit_ready = 1'b0;
    tick();

    // Capture and transmit_ready together in IDLE: capture only
    ready = 1'b1; transmit_ready = 1'b1; data = 8'h3C;
    tick();
    check_out("idle_cap_tr", 1'b1, 1'b0, 8'h05);
    tick();
    check_out("idle_cap_tr_send", 1'b0, 1'b1, 8'h3C);
    ready = 1'b0; transmit_ready = 1'b0;
    tick();
    check_out("idle_cap_tr_done", 1'b0, 1'b0, 8'h3C);

    // Capture wins over transmit_ready in HOLD; latest byte is sent one cycle later
    ready = 1'b1; data = 8'hA5;
    tick();
    check_out("prio_hold", 1'b1, 1'b0, 8'h3C);
    ready = 1'b0;
    tick();
    check_out("prio_wait", 1'b1, 1'b0, 8'h3C);
    ready = 1'b1; data = 8'h5A; transmit_ready = 1'b1;
    tick();
    check_out("prio_recap", 1'b1, 1'b0, 8'h3C);
    tick();
    check_out("prio_send", 1'b0, 1'b1, 8'h5A);
    ready = 1'b0; transmit_ready = 1'b0;
    tick();
    check_out("prio_idle", 1'b0, 1'b0, 8'h5A);

    // Capture during SEND is ignored
    ready = 1'b1; data = 8'h11;
    tick();
    check_out("sendcap_hold", 1'b1, 1'b0, 8'h5A);
    ready = 1'b0; transmit_ready = 1'b1;
    tick();
    check_out("sendcap_send", 1'b0, 1'b1, 8'h11);
    ready = 1'b1; data = 8'hC3; transmit_ready = 1'b0;
    tick();
    check_out("sendcap_ignored", 1'b0, 1'b0, 8'h11);
    tick();
    check_out("sendcap_no_recap", 1'b0, 1'b0, 8'h11);
    ready = 1'b0;
    tick();

    // 6. Asynchronous reset mid-HOLD, ready still high at release
    ready = 1'b1; data = 8'h99;
    tick();
    check_out("rst_hold", 1'b1, 1'b0, 8'h11);
    #2 nRst = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 1'b0, 8'h00);
    #1 nRst = 1'b1;
    tick();
    check_out("rst_recap", 1'b1, 1'b0, 8'h00);
    transmit_ready = 1'b1;
    tick();
    check_out("rst_send", 1'b0, 1'b1, 8'h99);
    ready = 1'b0; transmit_ready = 1'b0;
    tick();
    check_out("rst_idle", 1'b0, 1'b0, 8'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
